// File: rtl/apb_stream_uart_v2.sv
// rtl/apb_stream_uart_v2.sv - APB-controlled stream UART with TX FIFO, RS-485 DE sequencing, optional parity
// Parity support is built only when STREAM_UART_PARITY_EN is defined.
module apb_stream_uart_v2 #(
    parameter int              FIFO_DEPTH = 64,
    parameter int              DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd1040
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [3:0]  PSTRB,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        tx_tvalid,
    output logic        tx_tready,
    input  logic [7:0]  tx_tdata,
    output logic        rx_tvalid,
    output logic [7:0]  rx_tdata,
    output logic        UART_TX,
    input  logic        UART_RX,
    output logic        UART_DE,
    output logic        UART_RTS,
    output logic        UART_DTR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = DIV_W + 1;
`ifdef STREAM_UART_PARITY_EN
    localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
    localparam logic [7:0] CTRL_MASK = 8'hF3;
`endif

    typedef enum logic [2:0] {T_IDLE, T_LOAD, T_LEAD, T_START, T_DATA, T_PAR, T_STOP, T_GUARD} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

    tx_state_t        txst_q, txst_d;
    rx_state_t        rxst_q, rxst_d;
    logic [7:0]       ctrl_q, ctrl_d, tshift_q, tshift_d, rshift_q, rshift_d, rdata_q, rdata_d;
    logic [DIV_W-1:0] baud_q, baud_d, tcnt_q, tcnt_d, tbaud_q, tbaud_d, rcnt_q, rcnt_d, rbaud_q, rbaud_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [2:0]       tbit_q, tbit_d, rbit_q, rbit_d;
    logic ferr_q, ferr_d, perr_q, perr_d, rdy_q, rdy_d, tpar_q, tpar_d;
    logic tstop2_q, tstop2_d, tde_q, tde_d, tpen_q, tpen_d, todd_q, todd_d, tx_q, tx_d, de_q, de_d;
    logic rs1_q, rs1_d, rs2_q, rs2_d, rpe_q, rpe_d, rpen_q, rpen_d, rodd_q, rodd_d, rvalid_q, rvalid_d;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [7:0]       fifo_rd;
    logic [CW-1:0]    rhalf;
    logic             wr_en, push, pop, fifo_full, fifo_empty, ttick, rtick, par_on;
    logic             unused_apb;

    assign unused_apb = ^{PSTRB, PADDR, PWDATA};
    assign PREADY     = 1'b1;
    assign wr_en      = PSEL & PENABLE & PWRITE;
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign tx_tready  = rdy_q & ctrl_q[0] & ~fifo_full;
    assign push       = tx_tvalid & tx_tready;
    assign fifo_rd    = mem[rptr_q];
    assign ttick      = (tcnt_q == tbaud_q);
    assign rtick      = (rcnt_q == rbaud_q);
    assign rhalf      = ({1'b0, rbaud_q} + CW'(1)) >> 1;
    assign UART_TX    = tx_q;
    assign UART_DE    = de_q;
    assign UART_RTS   = ~ctrl_q[6];
    assign UART_DTR   = ~ctrl_q[7];
    assign rx_tvalid  = rvalid_q;
    assign rx_tdata   = rdata_q;
`ifdef STREAM_UART_PARITY_EN
    assign par_on = ctrl_q[3] ^ ctrl_q[2];
`else
    assign par_on = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (push) mem[wptr_q] <= tx_tdata;
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR[3:2])
                2'd0: PRDATA[7:0] = ctrl_q;
                2'd1: PRDATA[DIV_W-1:0] = baud_q;
                2'd2: PRDATA[4:0] = {perr_q, ferr_q, fifo_full, fifo_empty, txst_q != T_IDLE};
                default: PRDATA[10:0] = 11'(level_q);
            endcase
        end
    end

    always_comb begin
        ctrl_d = ctrl_q; baud_d = baud_q; ferr_d = ferr_q; perr_d = perr_q; rdy_d = 1'b1;
        txst_d = txst_q; tshift_d = tshift_q; tbit_d = tbit_q; tpar_d = tpar_q;
        tbaud_d = tbaud_q; tstop2_d = tstop2_q; tde_d = tde_q; tpen_d = tpen_q; todd_d = todd_q;
        rxst_d = rxst_q; rshift_d = rshift_q; rbit_d = rbit_q; rpe_d = rpe_q; rdata_d = rdata_q;
        rbaud_d = rbaud_q; rpen_d = rpen_q; rodd_d = rodd_q;
        rs1_d = UART_RX; rs2_d = rs1_q; rvalid_d = 1'b0; pop = 1'b0;
        tcnt_d = ttick ? '0 : tcnt_q + DIV_W'(1);
        rcnt_d = rtick ? '0 : rcnt_q + DIV_W'(1);

        if (wr_en) begin
            case (PADDR[3:2])
                2'd0: ctrl_d = PWDATA[7:0] & CTRL_MASK;
                2'd1: baud_d = (PWDATA[DIV_W-1:0] < DIV_W'(7)) ? DIV_W'(7) : PWDATA[DIV_W-1:0];
                2'd2: begin
                    if (PWDATA[3]) ferr_d = 1'b0;
                    if (PWDATA[4]) perr_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Frame configuration is captured only while idle so a live write never tears a frame.
        case (txst_q)
            T_IDLE: begin
                tcnt_d = '0; tbaud_d = baud_q; tstop2_d = ctrl_q[4]; tde_d = ctrl_q[5];
                tpen_d = par_on; todd_d = ctrl_q[3];
                if (ctrl_q[0] && !fifo_empty) begin
                    pop = 1'b1; txst_d = T_LOAD;
                end
            end
            T_LOAD: begin
                tcnt_d = '0; txst_d = tde_q ? T_LEAD : T_START;
            end
            T_LEAD:  if (ttick) txst_d = T_START;
            T_START: if (ttick) begin txst_d = T_DATA; tbit_d = '0; end
            T_DATA: if (ttick) begin
                tshift_d = tshift_q >> 1;
                tbit_d   = tbit_q + 3'd1;
                if (tbit_q == 3'd7) txst_d = tpen_q ? T_PAR : T_STOP;
            end
            T_PAR: if (ttick) txst_d = T_STOP;
            T_STOP: if (ttick) begin
                if (tstop2_q && tbit_q == 3'd0) tbit_d = 3'd1;
                else begin
                    tbit_d = '0;
                    if (ctrl_q[0] && !fifo_empty) begin
                        pop = 1'b1; txst_d = T_START;
                    end else txst_d = tde_q ? T_GUARD : T_IDLE;
                end
            end
            default: if (ttick) txst_d = T_IDLE;
        endcase
        if (pop) begin
            tshift_d = fifo_rd;
            tpar_d   = (^fifo_rd) ^ todd_d;
        end

        case (rxst_q)
            R_IDLE: begin
                rcnt_d = '0; rbaud_d = baud_q; rpen_d = par_on; rodd_d = ctrl_q[3];
                if (!rs2_q) rxst_d = R_START;
            end
            R_START: if (rcnt_q == rhalf[DIV_W-1:0]) begin
                rcnt_d = '0; rbit_d = '0; rpe_d = 1'b0;
                rxst_d = rs2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rtick) begin
                rshift_d = {rs2_q, rshift_q[7:1]};
                rbit_d   = rbit_q + 3'd1;
                if (rbit_q == 3'd7) rxst_d = rpen_q ? R_PAR : R_STOP;
            end
            R_PAR: if (rtick) begin
                rpe_d  = rs2_q ^ (^rshift_q) ^ rodd_q;
                rxst_d = R_STOP;
            end
            R_STOP: if (rtick) begin
                rvalid_d = ctrl_q[1];
                if (ctrl_q[1]) rdata_d = rshift_q;
                if (!rs2_q) ferr_d = 1'b1;
                if (rpe_q) perr_d = 1'b1;
                rxst_d = rs2_q ? R_IDLE : R_WAIT;
            end
            default: if (rs2_q) rxst_d = R_IDLE;
        endcase

        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        tx_d = 1'b1;
        case (txst_q)
            T_START: tx_d = 1'b0;
            T_DATA:  tx_d = tshift_q[0];
            T_PAR:   tx_d = tpar_q;
            default: tx_d = 1'b1;
        endcase
        de_d = tde_q && (txst_q != T_IDLE) && (txst_q != T_LOAD);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q <= 8'h03; baud_q <= DIV_RESET; ferr_q <= 1'b0; perr_q <= 1'b0; rdy_q <= 1'b0;
            wptr_q <= '0; rptr_q <= '0; level_q <= '0;
            txst_q <= T_IDLE; tcnt_q <= '0; tbit_q <= '0; tshift_q <= '0; tpar_q <= 1'b0;
            tbaud_q <= DIV_RESET; tstop2_q <= 1'b0; tde_q <= 1'b0; tpen_q <= 1'b0; todd_q <= 1'b0;
            tx_q <= 1'b1; de_q <= 1'b0;
            rs1_q <= 1'b1; rs2_q <= 1'b1; rxst_q <= R_IDLE; rcnt_q <= '0; rbit_q <= '0;
            rshift_q <= '0; rpe_q <= 1'b0; rbaud_q <= DIV_RESET; rpen_q <= 1'b0; rodd_q <= 1'b0;
            rvalid_q <= 1'b0; rdata_q <= '0;
        end else begin
            ctrl_q <= ctrl_d; baud_q <= baud_d; ferr_q <= ferr_d; perr_q <= perr_d; rdy_q <= rdy_d;
            wptr_q <= wptr_d; rptr_q <= rptr_d; level_q <= level_d;
            txst_q <= txst_d; tcnt_q <= tcnt_d; tbit_q <= tbit_d; tshift_q <= tshift_d; tpar_q <= tpar_d;
            tbaud_q <= tbaud_d; tstop2_q <= tstop2_d; tde_q <= tde_d; tpen_q <= tpen_d; todd_q <= todd_d;
            tx_q <= tx_d; de_q <= de_d;
            rs1_q <= rs1_d; rs2_q <= rs2_d; rxst_q <= rxst_d; rcnt_q <= rcnt_d; rbit_q <= rbit_d;
            rshift_q <= rshift_d; rpe_q <= rpe_d; rbaud_q <= rbaud_d; rpen_q <= rpen_d; rodd_q <= rodd_d;
            rvalid_q <= rvalid_d; rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_apb_stream_uart_v2.sv
// tb/tb_apb_stream_uart_v2.sv - directed self-checking bench for apb_stream_uart_v2
module tb_apb_stream_uart_v2;
    logic        PCLK = 1'b0, PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
    logic [3:0]  PSTRB = 4'hF;
    logic        PREADY, tx_tvalid = 1'b0, tx_tready, rx_tvalid;
    logic [7:0]  tx_tdata = '0, rx_tdata;
    logic        UART_TX, UART_RX, UART_DE, UART_RTS, UART_DTR;
    logic        rx_drv = 1'b1, loop_en = 1'b0;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] rxq[$];
    int         rxt[$];
    bit         burst = 1'b0, stall_seen = 1'b0, stall_bad = 1'b0;
    int         maxlvl = 0;

    assign UART_RX = loop_en ? UART_TX : rx_drv;

    apb_stream_uart_v2 dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
        .UART_TX(UART_TX), .UART_RX(UART_RX), .UART_DE(UART_DE), .UART_RTS(UART_RTS), .UART_DTR(UART_DTR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (rx_tvalid) begin
            rxq.push_back(rx_tdata);
            rxt.push_back(cyc);
        end
        if (burst) begin
            if (int'(PRDATA[10:0]) > maxlvl) maxlvl = int'(PRDATA[10:0]);
            if (tx_tvalid && !tx_tready) begin
                stall_seen = 1'b1;
                if (PRDATA[10:0] != 11'd64) stall_bad = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting", tag);
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK); PSEL = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
        @(negedge PCLK); PENABLE = 1;
        @(negedge PCLK); PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK); PSEL = 1; PWRITE = 0; PADDR = a;
        #1 d = PRDATA;
        PSEL = 0;
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        tx_tvalid = 1; tx_tdata = b;
        while (!tx_tready && n < 20000) begin @(negedge PCLK); n++; end
        if (n >= 20000) timeout("push");
        @(negedge PCLK);
    endtask

    task automatic wait_sig(input string tag, input int which, input logic val, output int c);
        int n = 0;
        while (((which == 0) ? UART_TX : UART_DE) !== val && n < 5000) begin @(negedge PCLK); n++; end
        if (n >= 5000) timeout(tag);
        c = cyc;
    endtask

    task automatic rx_bit(input logic v);
        rx_drv = v;
        repeat (10) @(negedge PCLK);
    endtask

    task automatic rx_frame(input logic [7:0] b, input int par, input logic stopv);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        if (par >= 0) rx_bit(par[0]);
        rx_bit(stopv);
        rx_drv = 1'b1;
        repeat (20) @(negedge PCLK);
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  pat;
        int c0, c1, r, s, f, n;

        repeat (3) @(negedge PCLK);
        chk("rst_tx", 32'(UART_TX), 1);
        chk("rst_de", 32'(UART_DE), 0);
        chk("rst_rts", 32'(UART_RTS), 1);
        chk("rst_dtr", 32'(UART_DTR), 1);
        chk("rst_rxv", 32'(rx_tvalid), 0);
        chk("rst_rxd", 32'(rx_tdata), 0);
        chk("rst_prdata", PRDATA, 0);
        PRESETn = 1;
        #1 chk("tready_first", 32'(tx_tready), 0);
        @(negedge PCLK);
        chk("tready_second", 32'(tx_tready), 1);

        apb_rd(32'h0, rd); chk("ctrl_rst", rd, 32'h03);
        apb_rd(32'h4, rd); chk("baud_rst", rd, 32'd1040);
        apb_rd(32'h8, rd); chk("status_rst", rd, 32'h02);
        apb_rd(32'hC, rd); chk("level_rst", rd, 0);

        apb_wr(32'h4, 32'd3);  apb_rd(32'h4, rd); chk("baud_min", rd, 32'd7);
        apb_wr(32'h4, 32'd9);  apb_rd(32'h4, rd); chk("baud_9", rd, 32'd9);
        apb_wr(32'h0, 32'hC3);
        @(negedge PCLK);
        chk("rts_on", 32'(UART_RTS), 0);
        chk("dtr_on", 32'(UART_DTR), 0);
        apb_wr(32'h0, 32'h03);
        @(negedge PCLK);
        chk("rts_off", 32'(UART_RTS), 1);

        // Single 8N1 frame of 0xA5 at 10 cycles per bit
        push(8'hA5);
        c0 = cyc;
        tx_tvalid = 0;
        wait_sig("a5_start", 0, 1'b0, c1);
        chk("a5_latency", 32'(c1 - c0), 3);
        pat = 10'b1101001010;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 4 : 10) @(negedge PCLK);
            chk($sformatf("a5_bit%0d", i), 32'(UART_TX), 32'(pat[i]));
        end
        apb_rd(32'h8, rd); chk("a5_busy", rd, 32'h03);
        repeat (6) @(negedge PCLK);
        apb_rd(32'h8, rd); chk("a5_idle", rd, 32'h02);

        // 70-byte burst through a loopback, BAUD=7 gives 80 cycles per frame
        apb_wr(32'h4, 32'd7);
        repeat (3) @(negedge PCLK);
        loop_en = 1;
        rxq.delete(); rxt.delete();
        PSEL = 1; PWRITE = 0; PADDR = 32'hC;
        burst = 1;
        for (int i = 0; i < 70; i++) push(8'((i * 37 + 5) & 8'hFF));
        tx_tvalid = 0;
        n = 0;
        while (rxq.size() < 70 && n < 8000) begin @(negedge PCLK); n++; end
        if (n >= 8000) timeout("burst_rx");
        burst = 0; PSEL = 0;
        loop_en = 0;
        chk("burst_maxlvl", 32'(maxlvl), 64);
        chk("burst_stall", 32'(stall_seen), 1);
        chk("burst_stall_lvl", 32'(stall_bad), 0);
        chk("burst_count", 32'(rxq.size()), 70);
        if (rxq.size() == 70) begin
            for (int i = 0; i < 70; i++)
                chk($sformatf("burst_byte%0d", i), 32'(rxq[i]), 32'((i * 37 + 5) & 8'hFF));
            chk("burst_nogap", 32'(rxt[69] - rxt[0]), 32'(69 * 80));
        end

        // RS-485 sequencing: de_en, stop2, two bytes at 10 cycles per bit
        apb_wr(32'h4, 32'd9);
        apb_wr(32'h0, 32'h33);
        repeat (3) @(negedge PCLK);
        push(8'h12);
        push(8'h34);
        tx_tvalid = 0;
        wait_sig("de_rise", 1, 1'b1, r);
        wait_sig("de_start", 0, 1'b0, s);
        wait_sig("de_fall", 1, 1'b0, f);
        chk("de_lead", 32'(s - r), 10);
        chk("de_hold", 32'(f - s), 230);
        repeat (5) @(negedge PCLK);
        apb_wr(32'h0, 32'h03);
        repeat (3) @(negedge PCLK);

        rxq.delete();
`ifdef STREAM_UART_PARITY_EN
        apb_wr(32'h0, 32'h07);
        apb_rd(32'h0, rd); chk("ctrl_par", rd, 32'h07);
        repeat (3) @(negedge PCLK);
        rx_frame(8'h03, 1, 1'b1);
        chk("par_count", 32'(rxq.size()), 1);
        if (rxq.size() > 0) chk("par_data", 32'(rxq[0]), 32'h03);
        apb_rd(32'h8, rd); chk("par_err_set", rd, 32'h12);
        apb_wr(32'h8, 32'h10);
        apb_rd(32'h8, rd); chk("par_err_clr", rd, 32'h02);
        apb_wr(32'h0, 32'h03);
        repeat (3) @(negedge PCLK);
`else
        apb_wr(32'h0, 32'h0F);
        apb_rd(32'h0, rd); chk("ctrl_nopar", rd, 32'h03);
        rx_frame(8'h03, -1, 1'b1);
        chk("nopar_count", 32'(rxq.size()), 1);
        if (rxq.size() > 0) chk("nopar_data", 32'(rxq[0]), 32'h03);
        apb_rd(32'h8, rd); chk("nopar_status", rd, 32'h02);
`endif

        rxq.delete();
        rx_frame(8'h55, -1, 1'b0);
        chk("ferr_count", 32'(rxq.size()), 1);
        if (rxq.size() > 0) chk("ferr_data", 32'(rxq[0]), 32'h55);
        apb_rd(32'h8, rd); chk("ferr_set", rd, 32'h0A);
        apb_wr(32'h8, 32'h08);
        apb_rd(32'h8, rd); chk("ferr_clr", rd, 32'h02);

        rxq.delete();
        rx_drv = 0;
        repeat (3) @(negedge PCLK);
        rx_drv = 1;
        repeat (40) @(negedge PCLK);
        chk("glitch_none", 32'(rxq.size()), 0);
        apb_rd(32'h8, rd); chk("glitch_status", rd, 32'h02);

        // Asynchronous reset in the middle of a start bit
        push(8'h0F);
        push(8'hF0);
        tx_tvalid = 0;
        wait_sig("abort_start", 0, 1'b0, c1);
        PSEL = 1; PWRITE = 0; PADDR = 32'hC;
        #1 chk("abort_level_before", PRDATA, 1);
        #1 PRESETn = 0;
        #1 chk("abort_tx", 32'(UART_TX), 1);
        chk("abort_level", PRDATA, 0);
        PSEL = 0;
        @(negedge PCLK);
        PRESETn = 1;
        repeat (2) @(negedge PCLK);
        apb_rd(32'h0, rd); chk("abort_ctrl", rd, 32'h03);
        apb_rd(32'hC, rd); chk("abort_level_after", rd, 0);
        repeat (5) @(negedge PCLK);
        chk("abort_tx_idle", 32'(UART_TX), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
